vga_scan_out: RTL and testbench
===============================

Name: vga_scan_out

Overview:
- Display-side end of the sprite pixel interface.
- Generates 640x480@60 Hz VGA timing and drives `row_addr`/`col_addr` to every sprite renderer.
- Takes back the ORed sprite pixel bit `px` and emits aligned RGB444 plus hsync/vsync.
- Also produces `fresh`; sprites advance their positions on its falling edge, which is the start of vertical blanking.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
PX_LAT, 1, clocks from address out to px valid (1..4)
FG_COLOR, 12'h535, RGB444 for px=1
BG_COLOR, 12'hFFF, RGB444 for px=0

Ports:
clk  input  1  pixel clock, 25 MHz (driven from clkdiv[1])
RESET  input  1  asynchronous, active-low reset
px  input  1  OR of sprite pixels, valid PX_LAT clocks after address
invert  input  1  swap FG/BG (night mode), sampled with px
row_addr  output  9  current line 0..479; 9'h1FF outside active lines
col_addr  output  10  current horizontal count 0..799
fresh  output  1  1 during active lines, 0 during vertical blanking
hs  output  1  hsync, active-low
vs  output  1  vsync, active-low
rgb  output  12  {R[3:0],G[3:0],B[3:0]}, 0 when blanked

Behaviour:

Counters:
- h_cnt runs 0..H_TOTAL-1 (H_TOTAL=800) and wraps to 0.
- v_cnt increments when h_cnt wraps, runs 0..V_TOTAL-1 (525) and wraps to 0.
- Frame = 420000 clocks.

Address outputs (registered, no delay vs counters):
- `col_addr` = h_cnt at all times.
- `row_addr` = v_cnt[8:0] when v_cnt<V_ACTIVE, else 9'h1FF.
- `fresh` = (v_cnt<V_ACTIVE):
  - falls in the same cycle v_cnt becomes 480 (h_cnt=0);
  - rises when v_cnt wraps to 0.

Timing, stage 0 (counter cycle):
- active = h_cnt<640 && v_cnt<480.
- hs_raw = 0 for h_cnt in [656,751].
- vs_raw = 0 for v_cnt in [490,491], full lines.

Alignment:
- active, hs_raw and vs_raw pass through a PX_LAT-deep shift register so they meet `px` for the same counter position.
- One output register stage follows:
  - `rgb` <= delayed_active ? ((px^invert)?FG_COLOR:BG_COLOR) : 12'h000
  - `hs` <= delayed hs_raw
  - `vs` <= delayed vs_raw
- Total latency from counter position to hs/vs/rgb = PX_LAT+1 clocks; hs, vs and rgb are mutually aligned.

Reset (asynchronous, RESET=0):
- h_cnt=0, v_cnt=0, col_addr=0, row_addr=0, fresh=1.
- Delay-line contents: active=0, hs=1, vs=1.
- hs=1, vs=1, rgb=0.
- Release starts line 0 pixel 0 on the first clk edge.

Reset mid-frame: all state returns to the values above immediately. No partial sync pulse may persist past assertion: hs/vs go to 1 asynchronously.

Boundaries:
- h_cnt=799 and v_cnt=524 wrap to 0 in the same cycle.
- During blanking, `px` and `invert` are ignored (rgb=0).
- `invert` toggling mid-line takes effect on the pixel sampled that cycle.
- No glitches on hs/vs: both are register outputs.

Test Plan:
1. Reset assert then release:
   - during reset: hs=1, vs=1, rgb=0, fresh=1, col_addr=0, row_addr=0;
   - after release: col_addr increments by 1 per clk.
2. Line timing with PX_LAT=1: hs low for exactly 96 clks, starting 2 clks after col_addr=656; hs period 800 clks.
3. Frame timing:
   - vs low for exactly 1600 clks, period 420000 clks;
   - fresh falls when row_addr goes 479 -> 9'h1FF;
   - fresh rises when row_addr goes to 0.
4. Pixel alignment:
   - bench drives px=1 only in the cycle after col_addr=100 on row 200;
   - rgb=FG_COLOR for exactly one clk, 2 clks after col_addr=100;
   - rgb=BG_COLOR elsewhere in active area, 0 in blanking.
5. invert=1 with px=0 in active area -> rgb=FG_COLOR; px=1 in blanking -> rgb=0.
6. Assert RESET at row 300, col 400 for 3 clks:
   - outputs return to reset values asynchronously;
   - after release, next hs pulse starts 658 clks later and next vs pulse follows 490 lines later.

Source files
------------

// File: rtl/vga_scan_out_if.sv
// Sprite pixel bus between the VGA scan-out block and the sprite renderers.
// The scan-out side drives addresses and video; the sprite side returns px/invert.
interface vga_scan_out_if;
  logic        px;
  logic        invert;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        fresh;
  logic        hs;
  logic        vs;
  logic [11:0] rgb;

  modport master (
    input  px, invert,
    output row_addr, col_addr, fresh, hs, vs, rgb
  );

  modport slave (
    output px, invert,
    input  row_addr, col_addr, fresh, hs, vs, rgb
  );
endinterface

// File: rtl/vga_scan_out.sv
// VGA 640x480@60 timing generator and pixel scan-out: drives sprite addresses,
// takes back the ORed sprite bit and emits aligned RGB444 with hsync/vsync.
module vga_scan_out #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PX_LAT   = 1,
  parameter logic [11:0] FG_COLOR = 12'h535,
  parameter logic [11:0] BG_COLOR = 12'hFFF
) (
  input  logic           clk,
  input  logic           RESET,
  vga_scan_out_if.master bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Raster position and the address registers derived from it.
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [8:0] row_q, row_d;
  logic       fresh_q, fresh_d;

  // Stage-0 timing flags and their alignment delay lines.
  logic              active_s, hs_raw_s, vs_raw_s;
  logic [PX_LAT-1:0] act_dl_q, act_dl_d;
  logic [PX_LAT-1:0] hs_dl_q, hs_dl_d;
  logic [PX_LAT-1:0] vs_dl_q, vs_dl_d;

  // Output register stage.
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q, vs_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end

    // Row address and fresh follow the next line count so they change on the
    // same edge as the counter itself.
    fresh_d = (v_cnt_d < V_ACT);
    row_d   = fresh_d ? v_cnt_d[8:0] : 9'h1FF;
  end

  always_comb begin
    active_s = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_raw_s = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    vs_raw_s = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
  end

  // Shift the newest flag in at bit 0; the oldest tap sits at PX_LAT-1 and
  // meets px for the same raster position.
  always_comb begin
    act_dl_d = PX_LAT'({act_dl_q, active_s});
    hs_dl_d  = PX_LAT'({hs_dl_q, hs_raw_s});
    vs_dl_d  = PX_LAT'({vs_dl_q, vs_raw_s});
  end

  // Blanked positions force black regardless of px and invert.
  always_comb begin
    rgb_d = '0;
    if (act_dl_q[PX_LAT-1]) begin
      rgb_d = (bus.px ^ bus.invert) ? FG_COLOR : BG_COLOR;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      row_q   <= '0;
      fresh_q <= 1'b1;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      row_q   <= row_d;
      fresh_q <= fresh_d;
    end
  end

  // NOTE: the delay lines are reset (not left as uninitialised storage) so no
  // stale sync level or active flag can leak out in the cycles after reset.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      act_dl_q <= '0;
      hs_dl_q  <= '1;
      vs_dl_q  <= '1;
    end else begin
      act_dl_q <= act_dl_d;
      hs_dl_q  <= hs_dl_d;
      vs_dl_q  <= vs_dl_d;
    end
  end

  // Sync outputs come straight from flops, so they cannot glitch.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= hs_dl_q[PX_LAT-1];
      vs_q  <= vs_dl_q[PX_LAT-1];
    end
  end

  assign bus.col_addr = h_cnt_q;
  assign bus.row_addr = row_q;
  assign bus.fresh    = fresh_q;
  assign bus.hs       = hs_q;
  assign bus.vs       = vs_q;
  assign bus.rgb      = rgb_q;

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out: full horizontal timing, vertical timing shortened to
// 20 lines so several frames fit in a short run; outputs compared to a raster model.
module tb_vga_scan_out;

  localparam int unsigned H_ACT  = 640;
  localparam int unsigned H_FP   = 16;
  localparam int unsigned H_SYNC = 96;
  localparam int unsigned H_BP   = 48;
  localparam int unsigned V_ACT  = 12;
  localparam int unsigned V_FP   = 3;
  localparam int unsigned V_SYNC = 2;
  localparam int unsigned V_BP   = 3;
  localparam int unsigned PX_LAT = 1;
  localparam int unsigned H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int unsigned FRAME  = H_TOT * V_TOT;
  localparam int unsigned LAT    = PX_LAT + 1;
  localparam logic [11:0] FG     = 12'h535;
  localparam logic [11:0] BG     = 12'hFFF;

  typedef struct packed {
    logic [9:0]  col;
    logic [8:0]  row;
    logic        fresh;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } obs_t;

  localparam obs_t RESET_VALS = '{col: 10'd0, row: 9'd0, fresh: 1'b1,
                                  hs: 1'b1, vs: 1'b1, rgb: 12'h000};

  logic clk = 1'b0;
  logic RESET;
  vga_scan_out_if vif ();

  vga_scan_out #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .PX_LAT(PX_LAT), .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .clk  (clk),
    .RESET(RESET),
    .bus  (vif.master)
  );

  always #5 clk = ~clk;

  int unsigned n;          // clock edges since the last reset release
  logic        px_prev;    // px driven during cycle n-1
  logic        inv_prev;   // invert driven during cycle n-1
  int          total = 0;
  int          bad   = 0;

  // Raster model: position n is (n mod 800, n/800 mod V_TOT); video outputs
  // describe position n-LAT combined with the px/invert presented at n-1.
  function automatic obs_t model(int unsigned cyc, logic pxp, logic invp);
    obs_t e;
    int unsigned h, v, hd, vd;
    h = cyc % H_TOT;
    v = (cyc / H_TOT) % V_TOT;
    e.col   = 10'(h);
    e.fresh = (v < V_ACT);
    e.row   = (v < V_ACT) ? 9'(v) : 9'h1FF;
    e.hs    = 1'b1;
    e.vs    = 1'b1;
    e.rgb   = 12'h000;
    if (cyc >= LAT) begin
      hd = (cyc - LAT) % H_TOT;
      vd = ((cyc - LAT) / H_TOT) % V_TOT;
      e.hs = !(hd >= H_ACT + H_FP && hd < H_ACT + H_FP + H_SYNC);
      e.vs = !(vd >= V_ACT + V_FP && vd < V_ACT + V_FP + V_SYNC);
      if (hd < H_ACT && vd < V_ACT) e.rgb = (pxp ^ invp) ? FG : BG;
    end
    return e;
  endfunction

  function automatic obs_t sample();
    return '{col: vif.col_addr, row: vif.row_addr, fresh: vif.fresh,
             hs: vif.hs, vs: vif.vs, rgb: vif.rgb};
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("col=%0d row=%h fresh=%b hs=%b vs=%b rgb=%h",
                     o.col, o.row, o.fresh, o.hs, o.vs, o.rgb);
  endfunction

  task automatic step();
    px_prev  = vif.px;
    inv_prev = vif.invert;
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic release_reset();
    RESET    = 1'b1;
    n        = 0;
    px_prev  = 1'b0;
    inv_prev = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    RESET      = 1'b0;
    vif.px     = 1'b0;
    vif.invert = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = sample();
    total++;
    if (got !== RESET_VALS) begin
      bad++;
      $display("FAIL reset_hold got %s want %s", fmt(got), fmt(RESET_VALS));
    end
    release_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      got = sample();
      exp = model(n, px_prev, inv_prev);
      total++;
      if (got.col !== 10'(i + 1) || got !== exp) begin
        bad++;
        $display("FAIL reset_release n=%0d got %s want %s", n, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_line_timing();
    obs_t got, exp;
    int fall1 = -1, fall2 = -1, low_cnt = 0;
    logic [9:0] c1, c2;
    logic hs_last;
    c1 = vif.col_addr;
    c2 = c1;
    hs_last = vif.hs;
    for (int i = 0; i < 3 * H_TOT && fall2 < 0; i++) begin
      vif.px     = 1'($urandom);
      vif.invert = 1'($urandom);
      c2 = c1;
      c1 = vif.col_addr;
      step();
      got = sample();
      exp = model(n, px_prev, inv_prev);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL line_cycle n=%0d got %s want %s", n, fmt(got), fmt(exp));
      end
      if (hs_last && !got.hs) begin
        if (fall1 < 0) begin
          fall1 = int'(n);
          total++;
          if (c2 !== 10'(H_ACT + H_FP)) begin
            bad++;
            $display("FAIL hs_start col two clks before fall got %0d want %0d", c2, H_ACT + H_FP);
          end
        end else begin
          fall2 = int'(n);
        end
      end
      if (!got.hs && fall1 >= 0 && fall2 < 0) low_cnt++;
      hs_last = got.hs;
    end
    total++;
    if (fall2 < 0) begin
      bad++;
      $display("FAIL hs_timeout got no second hsync fall want two");
    end else begin
      total++;
      if (low_cnt != int'(H_SYNC)) begin
        bad++;
        $display("FAIL hs_width got %0d want %0d", low_cnt, H_SYNC);
      end
      if (fall2 - fall1 != int'(H_TOT)) begin
        bad++;
        $display("FAIL hs_period got %0d want %0d", fall2 - fall1, H_TOT);
      end
    end
  endtask

  task automatic test_frame_timing();
    obs_t got, exp, prev;
    int fall1 = -1, fall2 = -1, low_cnt = 0, fresh_falls = 0, fresh_rises = 0;
    prev = sample();
    for (int i = 0; i < 2 * FRAME + H_TOT && fall2 < 0; i++) begin
      vif.px     = 1'($urandom);
      vif.invert = 1'($urandom);
      step();
      got = sample();
      exp = model(n, px_prev, inv_prev);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL frame_cycle n=%0d got %s want %s", n, fmt(got), fmt(exp));
      end
      if (prev.fresh && !got.fresh) begin
        fresh_falls++;
        total++;
        if (prev.row !== 9'(V_ACT - 1) || got.row !== 9'h1FF) begin
          bad++;
          $display("FAIL fresh_fall rows got %h->%h want %h->1ff", prev.row, got.row, 9'(V_ACT - 1));
        end
      end
      if (!prev.fresh && got.fresh) begin
        fresh_rises++;
        total++;
        if (got.row !== 9'h000 || got.col !== 10'd0) begin
          bad++;
          $display("FAIL fresh_rise got row=%h col=%0d want row=000 col=0", got.row, got.col);
        end
      end
      if (prev.vs && !got.vs) begin
        if (fall1 < 0) fall1 = int'(n);
        else           fall2 = int'(n);
      end
      if (!got.vs && fall1 >= 0 && fall2 < 0) low_cnt++;
      prev = got;
    end
    total++;
    if (fall2 < 0 || fresh_falls == 0 || fresh_rises == 0) begin
      bad++;
      $display("FAIL vs_timeout got vs_fall2=%0d fresh_falls=%0d fresh_rises=%0d want all seen",
               fall2, fresh_falls, fresh_rises);
    end else begin
      total++;
      if (low_cnt != int'(V_SYNC * H_TOT)) begin
        bad++;
        $display("FAIL vs_width got %0d want %0d", low_cnt, V_SYNC * H_TOT);
      end
      if (fall2 - fall1 != int'(FRAME)) begin
        bad++;
        $display("FAIL vs_period got %0d want %0d", fall2 - fall1, FRAME);
      end
    end
  endtask

  task automatic test_pixel_alignment();
    obs_t got, exp;
    logic found = 1'b0;
    int fg_seen = 0;
    vif.px     = 1'b0;
    vif.invert = 1'b0;
    for (int i = 0; i < FRAME + H_TOT && !found; i++) begin
      step();
      found = (vif.row_addr == 9'd5 && vif.col_addr == 10'd100);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL pix_timeout got no row 5 col 100 want reached");
      return;
    end
    step();
    vif.px = 1'b1;
    total++;
    if (vif.rgb !== BG) begin
      bad++;
      $display("FAIL pix_before got %h want %h", vif.rgb, BG);
    end
    step();
    vif.px = 1'b0;
    total++;
    if (vif.rgb !== FG) begin
      bad++;
      $display("FAIL pix_hit got %h want %h", vif.rgb, FG);
    end
    fg_seen = 1;
    for (int i = 0; i < int'(H_TOT); i++) begin
      step();
      got = sample();
      exp = model(n, px_prev, inv_prev);
      if (got.rgb === FG) fg_seen++;
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL pix_cycle n=%0d got %s want %s", n, fmt(got), fmt(exp));
      end
    end
    total++;
    if (fg_seen != 1) begin
      bad++;
      $display("FAIL pix_fg_count got %0d want 1", fg_seen);
    end
  endtask

  task automatic test_invert();
    logic found = 1'b0;
    for (int i = 0; i < int'(H_TOT) && !found; i++) begin
      step();
      found = (vif.col_addr == 10'd50 && vif.row_addr != 9'h1FF);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL inv_timeout got no active col 50 want reached");
      return;
    end
    step();
    vif.px     = 1'b0;
    vif.invert = 1'b1;
    step();
    vif.invert = 1'b0;
    total++;
    if (vif.rgb !== FG) begin
      bad++;
      $display("FAIL inv_active got %h want %h", vif.rgb, FG);
    end
    step();
    total++;
    if (vif.rgb !== BG) begin
      bad++;
      $display("FAIL inv_released got %h want %h", vif.rgb, BG);
    end
    found = 1'b0;
    for (int i = 0; i < int'(H_TOT) && !found; i++) begin
      step();
      found = (vif.col_addr == 10'd700);
    end
    vif.px = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (vif.rgb !== 12'h000) begin
        bad++;
        $display("FAIL px_in_blank got %h want 000", vif.rgb);
      end
    end
    vif.px = 1'b0;
  endtask

  task automatic test_mid_frame_reset();
    obs_t got, exp;
    logic found = 1'b0;
    logic hs_seen = 1'b0;
    for (int i = 0; i < FRAME + H_TOT && !found; i++) begin
      vif.px     = 1'($urandom);
      vif.invert = 1'($urandom);
      step();
      found = (vif.row_addr == 9'd8 && vif.col_addr == 10'd400);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL mid_timeout got no row 8 col 400 want reached");
      return;
    end
    #2 RESET = 1'b0;
    #1;
    got = sample();
    total++;
    if (got !== RESET_VALS) begin
      bad++;
      $display("FAIL mid_async got %s want %s", fmt(got), fmt(RESET_VALS));
    end
    repeat (3) @(posedge clk);
    #1;
    got = sample();
    total++;
    if (got !== RESET_VALS) begin
      bad++;
      $display("FAIL mid_held got %s want %s", fmt(got), fmt(RESET_VALS));
    end
    release_reset();
    for (int i = 0; i < 2 * int'(H_TOT) && !hs_seen; i++) begin
      step();
      hs_seen = !vif.hs;
    end
    total++;
    if (!hs_seen || n != H_ACT + H_FP + LAT) begin
      bad++;
      $display("FAIL mid_hs_start got %0d clks want %0d", n, H_ACT + H_FP + LAT);
    end
    found = 1'b0;
    for (int i = 0; i < FRAME && !found; i++) begin
      vif.px     = 1'($urandom);
      vif.invert = 1'($urandom);
      step();
      got = sample();
      exp = model(n, px_prev, inv_prev);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL mid_cycle n=%0d got %s want %s", n, fmt(got), fmt(exp));
      end
      found = !got.vs;
    end
    total++;
    if (!found || n != (V_ACT + V_FP) * H_TOT + LAT) begin
      bad++;
      $display("FAIL mid_vs_start got %0d clks want %0d", n, (V_ACT + V_FP) * H_TOT + LAT);
    end
  endtask

  task automatic test_reset_in_sync();
    obs_t got, exp;
    logic found = 1'b0;
    vif.px = 1'b0;
    for (int i = 0; i < int'(H_TOT) && !found; i++) begin
      step();
      found = (vif.col_addr == 10'd700);
    end
    got = sample();
    exp = model(n, px_prev, inv_prev);
    total++;
    if (!found || got !== exp || got.hs !== 1'b0 || got.vs !== 1'b0) begin
      bad++;
      $display("FAIL sync_pre got %s want %s with hs=0 vs=0", fmt(got), fmt(exp));
    end
    #2 RESET = 1'b0;
    #1;
    got = sample();
    total++;
    if (got !== RESET_VALS) begin
      bad++;
      $display("FAIL sync_async got %s want %s", fmt(got), fmt(RESET_VALS));
    end
    repeat (2) @(posedge clk);
    #1;
    release_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      got = sample();
      exp = model(n, px_prev, inv_prev);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL sync_after n=%0d got %s want %s", n, fmt(got), fmt(exp));
      end
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_pixel_alignment();
    test_invert();
    test_mid_frame_reset();
    test_reset_in_sync();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
